// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch queue: sequential fetch into a DEPTH-entry circular FIFO,
// head entry presented to IF, flush/restart on a taken branch or jump from EX.
module instr_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_redirect,
  input  logic [31:0]                i_redirect_pc,
  input  logic                       i_consume,
  output logic                       o_valid,
  output logic [31:0]                o_instruction,
  output logic [31:0]                o_pc,
  output logic [31:0]                o_pc_4,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_mem_req,
  output logic [31:0]                o_mem_addr,
  input  logic                       i_mem_ack,
  input  logic [31:0]                i_mem_rdata
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   instr_d [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   pc_d    [DEPTH];
  logic          push, pop;

  // Request depends only on state so memory never sees a path from consume/ack.
  assign o_mem_req     = (state_q == RUN) && (count_q < FULL);
  assign o_mem_addr    = fetch_pc_q;
  assign o_valid       = (count_q != '0);
  assign o_count       = count_q;
  assign o_instruction = instr_q[rd_ptr_q];
  assign o_pc          = pc_q[rd_ptr_q];
  assign o_pc_4        = pc_q[rd_ptr_q] + 32'd4;

  assign push = o_mem_req && i_mem_ack && !i_redirect;
  assign pop  = i_consume && o_valid && !i_redirect;

  always_comb begin
    state_d    = RUN;
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    if (i_redirect) begin
      // Redirect wins over everything, in RUN or FLUSH; any ack/consume is dropped.
      state_d    = FLUSH;
      fetch_pc_d = {i_redirect_pc[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        instr_d[wr_ptr_q] = i_mem_rdata;
        pc_d[wr_ptr_q]    = fetch_pc_q;
        wr_ptr_d          = wr_ptr_q + PW'(1);
        fetch_pc_d        = fetch_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer; memory returns ~addr as instruction.
module tb_instr_prefetch_buffer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  always #5 clk = ~clk;

  // main instance, RESET_PC = 0
  logic        redir, cons, ack;
  logic [31:0] redir_pc;
  logic        valid, mreq;
  logic [31:0] instr, pc, pc4, maddr;
  logic [2:0]  cnt;

  // second instance, RESET_PC near the top of the address space
  logic        redir2, cons2, ack2;
  logic        valid2, mreq2;
  logic [31:0] instr2, pc2, pc42, maddr2;
  logic [2:0]  cnt2;

  instr_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .i_redirect(redir), .i_redirect_pc(redir_pc),
    .i_consume(cons), .o_valid(valid), .o_instruction(instr), .o_pc(pc),
    .o_pc_4(pc4), .o_count(cnt), .o_mem_req(mreq), .o_mem_addr(maddr),
    .i_mem_ack(ack), .i_mem_rdata(~maddr));

  instr_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .reset(reset), .i_redirect(redir2), .i_redirect_pc(32'h0),
    .i_consume(cons2), .o_valid(valid2), .o_instruction(instr2), .o_pc(pc2),
    .o_pc_4(pc42), .o_count(cnt2), .o_mem_req(mreq2), .o_mem_addr(maddr2),
    .i_mem_ack(ack2), .i_mem_rdata(~maddr2));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs driven and outputs sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    redir = 0; redir_pc = 0; cons = 0; ack = 0;
    redir2 = 0; cons2 = 0; ack2 = 0;
    #12;
    // reset state
    chk("rst_valid", valid, 0);
    chk("rst_count", cnt, 0);
    chk("rst_req",   mreq, 1);
    chk("rst_addr",  maddr, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc",    pc, 0);
    chk("rst_pc4",   pc4, 4);
    chk("rst_addr2", maddr2, 32'hFFFF_FFF8);
    reset = 1;
    step();

    // fill to full with acks every cycle
    ack = 1;
    step();
    chk("fill1_valid", valid, 1);
    chk("fill1_count", cnt, 1);
    for (int i = 0; i < 3; i++) step();
    chk("full_count", cnt, 4);
    chk("full_req",   mreq, 0);
    chk("full_pc",    pc, 0);
    chk("full_instr", instr, 32'hFFFF_FFFF);
    chk("full_addr",  maddr, 32'h10);

    // stream: one pop per cycle, refill with no bubble
    cons = 1;
    step();
    chk("pop_req",   mreq, 1);
    chk("pop_count", cnt, 3);
    chk("stream_pc0", pc, 32'h4);
    for (int i = 1; i < 5; i++) begin
      step();
      chk("stream_pc",    pc, 32'h4 + 4*i);
      chk("stream_valid", valid, 1);
      chk("stream_count", cnt, 3);
    end
    chk("stream_instr", instr, ~32'h14);

    // redirect with count=3 and a simultaneous ack
    cons = 0; redir = 1; redir_pc = 32'h100;
    step();
    chk("flush_valid", valid, 0);
    chk("flush_count", cnt, 0);
    chk("flush_req",   mreq, 0);
    redir = 0;
    step();
    chk("restart_req",  mreq, 1);
    chk("restart_addr", maddr, 32'h100);
    step();
    chk("new_valid", valid, 1);
    chk("new_pc",    pc, 32'h100);
    chk("new_instr", instr, ~32'h100);
    chk("new_count", cnt, 1);

    // redirect again while in FLUSH, misaligned target
    ack = 0;
    redir = 1; redir_pc = 32'h300;
    step();
    redir_pc = 32'h203;
    step();
    redir = 0;
    chk("reflush_req", mreq, 0);
    step();
    chk("misalign_req",  mreq, 1);
    chk("misalign_addr", maddr, 32'h200);

    // sparse acks: every 3rd cycle, consume always on
    redir = 1; redir_pc = 32'h400;
    step();
    redir = 0; cons = 1;
    step();
    step();
    chk("sparse_addr0", maddr, 32'h400);
    for (int i = 0; i < 3; i++) begin
      ack = 1;
      step();
      chk("sparse_valid1", valid, 1);
      chk("sparse_pc",     pc, 32'h400 + 4*i);
      chk("sparse_count1", cnt, 1);
      ack = 0;
      step();
      chk("sparse_count0", cnt, 0);
      chk("sparse_hold_a", maddr, 32'h404 + 4*i);
      step();
      chk("sparse_valid0", valid, 0);
      chk("sparse_hold_b", maddr, 32'h404 + 4*i);
    end

    // consume while empty
    for (int i = 0; i < 5; i++) begin
      step();
      chk("empty_count", cnt, 0);
    end
    cons = 0; ack = 1;
    step();
    chk("after_empty_pc",    pc, 32'h40C);
    chk("after_empty_count", cnt, 1);
    ack = 0;

    // address wrap on the second instance
    ack2 = 1;
    step();
    chk("wrap_addr1", maddr2, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr2", maddr2, 32'h0);
    step();
    chk("wrap_count", cnt2, 3);
    chk("wrap_pc0",   pc2, 32'hFFFF_FFF8);
    ack2 = 0; cons2 = 1;
    step();
    chk("wrap_pc1",  pc2, 32'hFFFF_FFFC);
    chk("wrap_pc4",  pc42, 32'h0);
    step();
    chk("wrap_pc2",    pc2, 32'h0);
    chk("wrap_instr2", instr2, 32'hFFFF_FFFF);
    cons2 = 0;

    // asynchronous reset mid-burst
    ack = 1;
    step();
    step();
    #2 reset = 0;
    #1;
    chk("areset_valid", valid, 0);
    chk("areset_count", cnt, 0);
    chk("areset_addr",  maddr, 32'h0);
    #3 reset = 1;
    step();
    chk("resume_pc",    pc, 32'h0);
    chk("resume_count", cnt, 1);
    chk("resume_addr",  maddr, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
